// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: EX/MEM consumer with req/ack data-memory handshake and MEM/WB registers.
// Optional macro MISALIGN_TRAP_EN: trap misaligned accesses (misalign_o) instead of rounding the address.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_i,
    input  logic        MemtoReg_i,
    input  logic        MemWrite_i,
    input  logic        RegWrite_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] MemData_i,
    input  logic [4:0]  rd_i,
    input  logic [2:0]  funct3_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALUResult_o,
    output logic [4:0]  rd_o,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic        err_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic {IDLE, REQ} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    function automatic size_t size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return SZ_B;
            3'b001, 3'b101: return SZ_H;
            default:        return SZ_W;
        endcase
    endfunction

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;

    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic [2:0]  cap_f3;
    logic        cap_we, cap_regwrite, cap_memtoreg;
    logic [4:0]  cap_rd;

    logic        mem_op, mis_trap, ack_hit, timeout_hit;
    size_t       size_in;
    logic [3:0]  be_in;
    logic [31:0] wdata_in, load_data;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign mem_op      = MemRead_i | MemWrite_i;
    assign size_in     = size_of(funct3_i);
    assign ack_hit     = (state == REQ) & dmem_ack_i;
    assign timeout_hit = TIMEOUT_EN & (state == REQ) & ~dmem_ack_i & (cnt == CNT_LAST);

`ifdef MISALIGN_TRAP_EN
    assign mis_trap = (state == IDLE) & mem_op &
                      (((size_in == SZ_H) & ALUResult_i[0]) |
                       ((size_in == SZ_W) & (ALUResult_i[1:0] != 2'b00)));
`else
    assign mis_trap = 1'b0;
`endif

    // Store lanes: without the trap, low address bits below the access size are ignored.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        be_in    = 4'b1111;
        wdata_in = MemData_i;
        case (size_in)
            SZ_B: begin
                be_in    = 4'b0001 << ALUResult_i[1:0];
                wdata_in = {4{MemData_i[7:0]}};
            end
            SZ_H: begin
                be_in    = ALUResult_i[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{MemData_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_b    = dmem_rdata_i[{cap_addr[1:0], 3'b000} +: 8];
        lane_h    = cap_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        load_data = dmem_rdata_i;
        case (size_of(cap_f3))
            SZ_B:    load_data = cap_f3[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_H:    load_data = cap_f3[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (mem_op && !mis_trap) state_nx = REQ;
            REQ:  if (ack_hit || timeout_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = '0;
        dmem_wdata_o = '0;
        if (state == REQ) begin
            dmem_req_o   = 1'b1;
            dmem_we_o    = cap_we;
            dmem_addr_o  = {cap_addr[31:2], 2'b00};
            dmem_be_o    = cap_be;
            dmem_wdata_o = cap_wdata;
        end
        stall_o = mem_op & ~ack_hit & ~timeout_hit & ~mis_trap;
    end

    // Request copy is only visible on the ports in REQ, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && mem_op) begin
            cap_addr     <= ALUResult_i;
            cap_wdata    <= wdata_in;
            cap_be       <= be_in;
            cap_f3       <= funct3_i;
            cap_we       <= MemWrite_i;
            cap_regwrite <= RegWrite_i;
            cap_memtoreg <= MemtoReg_i;
            cap_rd       <= rd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite_o  <= 1'b0;
            MemtoReg_o  <= 1'b0;
            ReadData_o  <= '0;
            ALUResult_o <= '0;
            rd_o        <= '0;
            err_o       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_o  <= 1'b0;
`endif
            cnt         <= '0;
        end else begin
            // Default is a WB bubble; the cases below overwrite it when a result retires.
            RegWrite_o  <= 1'b0;
            MemtoReg_o  <= 1'b0;
            ReadData_o  <= '0;
            ALUResult_o <= '0;
            rd_o        <= '0;
            err_o       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_o  <= mis_trap;
`endif
            cnt         <= '0;
            if (state == IDLE) begin
                if (!mem_op) begin
                    RegWrite_o  <= RegWrite_i & (rd_i != 5'd0);
                    MemtoReg_o  <= MemtoReg_i;
                    ALUResult_o <= ALUResult_i;
                    rd_o        <= rd_i;
                end
            end else if (ack_hit || timeout_hit) begin
                RegWrite_o  <= cap_regwrite & (cap_rd != 5'd0);
                MemtoReg_o  <= cap_memtoreg;
                ALUResult_o <= cap_addr;
                rd_o        <= cap_rd;
                ReadData_o  <= (ack_hit && !cap_we) ? load_data : '0;
                err_o       <= timeout_hit;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register. It takes the latched control, ALU result, store data and rd, and runs a req/ack handshake with data memory. Byte/half/word lanes are handled on both stores and loads. Results are registered into MEM/WB-facing outputs. stall_o freezes the upstream pipeline while a memory access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max REQ cycles before the access is abandoned; 0 disables the timeout.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
MemRead_i  in  1  load request from the EX/MEM register
MemtoReg_i  in  1  writeback source select (pass-through)
MemWrite_i  in  1  store request
RegWrite_i  in  1  register write enable (pass-through)
ALUResult_i  in  32  effective address / ALU result
MemData_i  in  32  store data (rs2)
rd_i  in  5  destination register
funct3_i  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
dmem_req_o  out  1  memory request, held until ack
dmem_we_o  out  1  1 = store
dmem_addr_o  out  32  word-aligned address, ALUResult with [1:0] cleared
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_ack_i  in  1  one-cycle completion strobe
dmem_rdata_i  in  32  read word, valid with ack
stall_o  out  1  combinational; upstream holds inputs while 1
RegWrite_o, MemtoReg_o  out  1 each  registered pass-through
ReadData_o  out  32  aligned, extended load data
ALUResult_o  out  32  registered pass-through
rd_o  out  5  registered pass-through
err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values: state IDLE; every output 0; timeout counter 0.
- State IDLE:
  - Non-memory op (MemRead_i=MemWrite_i=0): next edge registers RegWrite/MemtoReg/ALUResult/rd. ReadData_o=0. 1-cycle latency; stall_o=0.
  - Memory op: capture address, data, funct3, control and rd internally. Next edge enters REQ with dmem_req_o=1. WB outputs become a bubble (RegWrite_o=0).
- State REQ:
  - dmem_req/we/addr/be/wdata are driven from the captured copy and stay stable until ack.
  - Each cycle without ack: WB bubble; counter increments.
  - On dmem_ack_i=1: stall_o drops the same cycle. Next edge loads WB outputs (load: ReadData from dmem_rdata_i), dmem_req_o=0, state returns to IDLE.
- Minimum memory-op latency is 2 cycles, ack in the first REQ cycle.
- stall_o = (MemRead_i|MemWrite_i) & ~(state==REQ & dmem_ack_i) & ~misaligned_trap.
- Timeout: if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with no ack:
  - Abandon the access; next edge goes to IDLE.
  - Write the WB result with ReadData_o=0, RegWrite_o per the captured control.
  - err_o=1 for one cycle; stall_o drops in the abandon cycle.
- Both MemRead_i and MemWrite_i set: treat as a store and ignore the read.
- rd_i=0: RegWrite_o forced 0.
- Ack while IDLE: ignored.
- Lanes, with off=ALUResult[1:0]:
  - Byte: be=0001<<off; wdata = byte replicated x4.
  - Half: be=0011<<(off[1]*2); wdata = half replicated x2.
  - Word: be=1111.
  - Loads select the lane the same way. b/h sign-extend; bu/hu zero-extend.
  - Unlisted funct3 codes are treated as word.
- Misaligned access (half with off[0]=1, word with off!=0) without the feature: off[0] is ignored for half, off is ignored for word.
- rst asserted in any state:
  - Next edge returns to IDLE and clears all outputs, including dmem_req_o.
  - Counter clears; the in-flight access is dropped.
  - An ack arriving after reset is ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: adds output misalign_o (1 bit, reset 0). A misaligned op in IDLE is not issued (dmem_req_o stays 0) and stall_o=0. Next edge gives a WB bubble (RegWrite_o=0) and misalign_o=1 for one cycle.
- Undefined: port absent; rounding behaviour as above.

Test Plan:
- Reset then ALU op, ALUResult_i=0x1234, rd=5, RegWrite=1 → next edge ALUResult_o=0x1234, rd_o=5, RegWrite_o=1; stall_o=0 throughout.
- lw addr 0x100, ack 3 cycles after req with rdata=0xDEADBEEF → dmem_addr_o=0x100, be=1111; stall_o high until the ack cycle; ReadData_o=0xDEADBEEF; RegWrite_o=0 during the wait.
- sb addr 0x103, data 0xAB → be=1000, wdata=0xABABABAB, we=1; ack → RegWrite_o=0, state IDLE.
- lb/lbu addr 0x102, rdata=0x00800000 → lb gives ReadData_o=0xFFFFFF80, lbu gives 0x00000080. lh at 0x102 with rdata=0x80010000 → 0xFFFF8001.
- TIMEOUT_CYCLES=4, no ack → after 4 REQ cycles err_o pulses, ReadData_o=0, req drops; rst asserted mid-REQ → req 0 next edge, a late ack causes no WB.
- With MISALIGN_TRAP_EN: lw addr 0x101 → no req, misalign_o=1 for one cycle, RegWrite_o=0, stall_o=0.
